// File: rtl/ctcls_recovery_ctrl.sv
// Recovery sequencer for the triple-core lock-step cluster: classifies voter mismatches,
// keeps per-core saturating counters and walks the IRQ / unload / reload resync sequence.
module ctcls_recovery_ctrl #(
    parameter int unsigned TimeoutCycles = 4096,
    parameter int unsigned CntWidth      = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic                     error_valid_i,
    input  logic [2:0]               error_cba_i,
    input  logic                     restore_mode_i,
    input  logic [2:0]               resync_ack_i,
    input  logic                     unload_done_i,
    input  logic                     reload_done_i,
    output logic [2:0]               resync_irq_o,
    output logic                     resync_active_o,
    output logic [1:0]               faulty_core_o,
    output logic [2:0][CntWidth-1:0] mismatch_cnt_o,
    output logic                     multi_fault_o,
    output logic                     fatal_o,
    output logic [2:0]               state_o
);

    localparam int unsigned WdWidth = $clog2(TimeoutCycles + 1);

    localparam logic [2:0] StRun    = 3'd0;
    localparam logic [2:0] StIrq    = 3'd1;
    localparam logic [2:0] StUnload = 3'd2;
    localparam logic [2:0] StReload = 3'd3;
    localparam logic [2:0] StFail   = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [2:0]               ack_q, ack_d;
    logic [WdWidth-1:0]       wdog_q, wdog_d;
    logic [1:0]               faulty_q, faulty_d;
    logic [2:0][CntWidth-1:0] cnt_q, cnt_d;
    logic                     multi_q, multi_d;

    logic [2:0] ack_all;
    logic [1:0] core_idx;
    logic       wd_expired;

    assign ack_all    = ack_q | resync_ack_i;
    // Only meaningful when error_cba_i is one-hot.
    assign core_idx   = error_cba_i[1] ? 2'd1 : (error_cba_i[2] ? 2'd2 : 2'd0);
    assign wd_expired = (wdog_q == WdWidth'(TimeoutCycles - 1));

    always_comb begin
        state_d  = state_q;
        ack_d    = ack_q;
        wdog_d   = wdog_q;
        faulty_d = faulty_q;
        cnt_d    = cnt_q;
        multi_d  = multi_q;
        if (!enable_i) begin
            state_d = StRun;
            ack_d   = '0;
            wdog_d  = '0;
        end else begin
            case (state_q)
                StRun: begin
                    if (error_valid_i) begin
                        case (error_cba_i)
                            3'b000: ;
                            3'b001, 3'b010, 3'b100: begin
                                if (cnt_q[core_idx] != {CntWidth{1'b1}}) begin
                                    cnt_d[core_idx] = cnt_q[core_idx] + CntWidth'(1);
                                end
                                faulty_d = core_idx;
                                if (!restore_mode_i) begin
                                    state_d = StIrq;
                                    ack_d   = '0;
                                    wdog_d  = '0;
                                end
                            end
                            default: begin
                                multi_d = 1'b1;
                                state_d = StFail;
                                wdog_d  = '0;
                            end
                        endcase
                    end
                end
                StIrq: begin
                    ack_d = ack_all;
                    if (ack_all == 3'b111) begin
                        state_d = StUnload;
                        wdog_d  = '0;
                    end else if (wd_expired) begin
                        state_d = StFail;
                        wdog_d  = '0;
                    end else begin
                        wdog_d = wdog_q + WdWidth'(1);
                    end
                end
                StUnload: begin
                    if (unload_done_i) begin
                        state_d = StReload;
                        wdog_d  = '0;
                    end else if (wd_expired) begin
                        state_d = StFail;
                        wdog_d  = '0;
                    end else begin
                        wdog_d = wdog_q + WdWidth'(1);
                    end
                end
                StReload: begin
                    if (reload_done_i) begin
                        state_d = StRun;
                        wdog_d  = '0;
                    end else if (wd_expired) begin
                        state_d = StFail;
                        wdog_d  = '0;
                    end else begin
                        wdog_d = wdog_q + WdWidth'(1);
                    end
                end
                StFail: ;
                default: begin
                    state_d = StRun;
                    ack_d   = '0;
                    wdog_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StRun;
            ack_q    <= '0;
            wdog_q   <= '0;
            faulty_q <= '0;
            cnt_q    <= '0;
            multi_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            wdog_q   <= wdog_d;
            faulty_q <= faulty_d;
            cnt_q    <= cnt_d;
            multi_q  <= multi_d;
        end
    end

    assign resync_irq_o    = (state_q == StIrq) ? ~ack_q : 3'b000;
    assign resync_active_o = (state_q == StIrq) || (state_q == StUnload) || (state_q == StReload);
    assign fatal_o         = (state_q == StFail);
    assign faulty_core_o   = faulty_q;
    assign mismatch_cnt_o  = cnt_q;
    assign multi_fault_o   = multi_q;
    assign state_o         = state_q;

endmodule
